io_xbar_output_port_rr: RTL



---
 rtl/io_xbar_pkg.sv | 37 +++
 rtl/io_xbar_rr_arbiter.sv | 30 +++
 rtl/io_xbar_output_port_rr.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/io_xbar_pkg.sv
// Shared state type and NoC header field positions for the I/O crossbar output port.
// Width macros default here when no NoC-wide definitions were included earlier.
`ifndef CHIP_ID_WIDTH
`define CHIP_ID_WIDTH 14
`endif
`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif
`ifndef PAYLOAD_LEN
`define PAYLOAD_LEN 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

package io_xbar_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } xbar_state_e;

    // Payload length sits directly below chip id and the X/Y coordinates.
    localparam int unsigned LEN_HI    = `DATA_WIDTH - 1 - `CHIP_ID_WIDTH - 2 * `XY_WIDTH;
    localparam int unsigned LEN_LO    = LEN_HI - `PAYLOAD_LEN + 1;
    localparam int unsigned USER_HI   = 23;
    localparam int unsigned USER_LO   = 20;
    localparam int unsigned SENDER_HI = 19;
    localparam int unsigned SENDER_LO = 10;
    localparam int unsigned SENDER_W  = SENDER_HI - SENDER_LO + 1;

    localparam logic [3:0] USER_INTR = 4'b1111;
    localparam logic [3:0] USER_MACK = 4'b1110;

    localparam int unsigned CREDIT_W = 4;

endpackage

// File: rtl/io_xbar_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo NUM_IN.
module io_xbar_rr_arbiter #(
    parameter int unsigned NUM_IN = 8,
    localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_IN-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              any
);

    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            idx = (32'(ptr) + k) % NUM_IN;
            if (!any && req[IDX_W'(idx)]) begin
                any                = 1'b1;
                grant[IDX_W'(idx)] = 1'b1;
                grant_idx          = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/io_xbar_output_port_rr.sv
// Crossbar output port: round-robin wormhole arbitration, valid/yummy credits, header kill.
// Optional stall watchdog enabled by defining IO_XBAR_OUT_WATCHDOG_EN.
module io_xbar_output_port_rr
    import io_xbar_pkg::*;
#(
    parameter int unsigned NUM_IN       = 8,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned CREDITS      = 4,
    parameter logic        KILL_HEADERS = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_IN-1:0]            valid_in,
    input  logic [NUM_IN-1:0]            route_req_in,
    input  logic [NUM_IN-1:0]            tail_in,
    input  logic [NUM_IN*DATA_WIDTH-1:0] data_in,
    input  logic                         default_ready_in,
    input  logic                         yummy_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    output logic [NUM_IN-1:0]            thanks_out,
    output logic                         popped_interrupt_mesg_out,
    output logic                         popped_memory_ack_mesg_out,
    output logic [SENDER_W-1:0]          popped_memory_ack_mesg_out_sender,
    output logic                         ec_wants_to_send_but_cannot
`ifdef IO_XBAR_OUT_WATCHDOG_EN
    ,
    output logic                         watchdog_err_out
`endif
);

    localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int unsigned LEN_W = LEN_HI - LEN_LO + 1;
    localparam int unsigned USR_W = USER_HI - USER_LO + 1;

    xbar_state_e             state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
    logic [CREDIT_W-1:0]     credit_cnt;

    logic [NUM_IN-1:0]       req_vec;
    logic [NUM_IN-1:0]       arb_grant;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_any;

    logic [IDX_W-1:0]        sel;
    logic                    xfer;
    logic                    is_hdr;
    logic                    has_credit;
    logic                    kill;
    logic [DATA_WIDTH-1:0]   sel_flit;
    logic [LEN_W-1:0]        hdr_len;
    logic [USR_W-1:0]        hdr_user;

    function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] i);
        return (32'(i) == NUM_IN - 1) ? '0 : i + 1'b1;
    endfunction

    // New packets only compete while downstream allows new grants.
    assign req_vec    = default_ready_in ? (route_req_in & valid_in) : '0;
    assign has_credit = (credit_cnt != '0);

    io_xbar_rr_arbiter #(
        .NUM_IN (NUM_IN)
    ) u_arb (
        .req       (req_vec),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    // Next state, selection and transfer decision; nothing moves while reset is held.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        sel         = arb_idx;
        xfer        = 1'b0;
        is_hdr      = 1'b0;
        unique case (state_q)
            IDLE: begin
                sel    = arb_idx;
                is_hdr = 1'b1;
                if (rst_n && arb_any && |arb_grant && (has_credit || KILL_HEADERS)) begin
                    xfer = 1'b1;
                    if (tail_in[arb_idx]) begin
                        rr_ptr_d = inc_wrap(arb_idx);
                    end else begin
                        state_d     = LOCKED;
                        grant_idx_d = arb_idx;
                    end
                end
            end
            LOCKED: begin
                sel = grant_idx_q;
                if (rst_n && valid_in[grant_idx_q] && has_credit) begin
                    xfer = 1'b1;
                    if (tail_in[grant_idx_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = inc_wrap(grant_idx_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sel_flit = data_in[32'(sel) * DATA_WIDTH +: DATA_WIDTH];
    assign hdr_len  = sel_flit[LEN_HI:LEN_LO];
    assign hdr_user = sel_flit[USER_HI:USER_LO];
    assign kill     = is_hdr & KILL_HEADERS;

    // Output drive for the current transfer cycle.
    always_comb begin
        data_out                          = sel_flit;
        valid_out                         = xfer & ~kill;
        thanks_out                        = '0;
        popped_interrupt_mesg_out         = 1'b0;
        popped_memory_ack_mesg_out        = 1'b0;
        popped_memory_ack_mesg_out_sender = '0;
        ec_wants_to_send_but_cannot       = 1'b0;
        if (xfer) begin
            thanks_out[sel] = 1'b1;
        end
        if (xfer && kill && hdr_len == '0) begin
            popped_interrupt_mesg_out  = (hdr_user == USER_INTR);
            popped_memory_ack_mesg_out = (hdr_user == USER_MACK);
        end
        if (KILL_HEADERS) begin
            popped_memory_ack_mesg_out_sender = sel_flit[SENDER_HI:SENDER_LO];
        end
        if (rst_n && !has_credit) begin
            ec_wants_to_send_but_cannot =
                ((state_q == IDLE) && arb_any && !KILL_HEADERS) ||
                ((state_q == LOCKED) && valid_in[grant_idx_q]);
        end
    end

    // Downstream credit counter; a return while already full saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_cnt <= CREDIT_W'(CREDITS);
        end else begin
            unique case ({valid_out, yummy_in})
                2'b10:   credit_cnt <= credit_cnt - 1'b1;
                2'b01:   credit_cnt <= (credit_cnt == CREDIT_W'(CREDITS)) ? credit_cnt
                                                                          : credit_cnt + 1'b1;
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    credit_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(yummy_in && !valid_out && credit_cnt == CREDIT_W'(CREDITS)))
        else $warning("io_xbar_output_port_rr: credit returned while counter full");

`ifdef IO_XBAR_OUT_WATCHDOG_EN
    logic [15:0] stall_cnt;

    // Counts LOCKED cycles without progress; the error flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt        <= '0;
            watchdog_err_out <= 1'b0;
        end else begin
            if (xfer || state_d == IDLE) begin
                stall_cnt <= '0;
            end else if (stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (stall_cnt == 16'hFFFF) begin
                watchdog_err_out <= 1'b1;
            end
        end
    end
`endif

endmodule
